// File: rtl/eth_lsab_pkg.sv
// Shared LSAB packer/unpacker definitions: FSM encoding, length width, turn codes.
package eth_lsab_pkg;

   localparam int LSAB_LEN_W = 24;

   localparam logic [1:0] LSAB_TURN_RECV = 2'd0;
   localparam logic [1:0] LSAB_TURN_SEND = 2'd1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RECV,
      ST_DROP,
      ST_FLUSH,
      ST_REPORT
   } rx_state_e;

endpackage

// File: rtl/lsab_word_fifo.sv
// Small synchronous word FIFO between the byte packer and the LSAB drain.
module lsab_word_fifo #(
   parameter int AW = 2,
   parameter int DW = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          pop_i,
   output logic [DW-1:0] rdata_o,
   output logic          full_o,
   output logic          empty_o,
   output logic          push_ok_o
);

   logic [DW-1:0] mem_q [2**AW];
   logic [AW:0]   wptr_q, wptr_d;
   logic [AW:0]   rptr_q, rptr_d;
   logic          do_push, do_pop;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                    (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

   // A pop in the same cycle frees the slot a full FIFO needs.
   assign do_pop    = pop_i && !empty_o;
   assign push_ok_o = !full_o || do_pop;
   assign do_push   = push_i && push_ok_o;

   assign rdata_o = mem_q[rptr_q[AW-1:0]];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/eth_recv_lsab_packer.sv
// Receive byte stream to LSAB word packer with per-frame completion interrupt.
module eth_recv_lsab_packer
   import eth_lsab_pkg::*;
#(
   parameter logic [1:0] LSAB_TURN = LSAB_TURN_RECV,
   parameter int         FIFO_AW   = 2,
   parameter int         MAX_FRAME = 1536,
   parameter int         LEN_W     = LSAB_LEN_W
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [7:0]       IN_DATA,
   input  logic             IN_STB,
   input  logic             IN_EOF,
   input  logic             IN_ABORT,
   output logic             IN_READY,
   input  logic [1:0]       LSAB_RECV_TURN,
   input  logic             LSAB_FULL,
   output logic [31:0]      DATA_RECV,
   output logic             WRITE_INTO_LSAB,
   output logic             IRQ,
   output logic             IRQ_VLD,
   output logic [LEN_W-1:0] FRAME_LEN
);

   rx_state_e        state_q, state_d;
   logic [31:0]      shreg_q, shreg_d;
   logic [1:0]       lane_q, lane_d;
   logic [LEN_W-1:0] len_q, len_d, len_inc;
   logic             bad_q, bad_d;
   logic             pend_q, pend_d;
   logic             vld_q, vld_d;
   logic [LEN_W-1:0] flen_q, flen_d;
   logic             wr_q;
   logic [31:0]      data_q;

   logic             push;
   logic [31:0]      push_word, word_ins;
   logic             pop, push_ok;
   logic             f_full, f_empty;
   logic [31:0]      f_rdata;
   logic             acc_byte, acc_eof, acc_abort, in_frame;

   assign IN_READY = !RST && (state_q == ST_IDLE ||
                              state_q == ST_RECV ||
                              state_q == ST_DROP);

   assign acc_byte  = IN_READY && IN_STB;
   assign acc_eof   = IN_READY && IN_EOF;
   assign acc_abort = IN_READY && IN_ABORT;
   assign in_frame  = (state_q == ST_RECV) || acc_byte;

   assign word_ins = shreg_q | ({24'b0, IN_DATA} << {lane_q, 3'b000});
   assign len_inc  = (len_q == '1) ? len_q : len_q + 1'b1;

   assign pop = !f_empty && (LSAB_RECV_TURN == LSAB_TURN) && !LSAB_FULL;

   lsab_word_fifo #(
      .AW (FIFO_AW),
      .DW (32)
   ) u_fifo (
      .clk_i     (CLK),
      .rst_i     (RST),
      .push_i    (push),
      .wdata_i   (push_word),
      .pop_i     (pop),
      .rdata_o   (f_rdata),
      .full_o    (f_full),
      .empty_o   (f_empty),
      .push_ok_o (push_ok)
   );

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      lane_d    = lane_q;
      len_d     = len_q;
      bad_d     = bad_q;
      pend_d    = pend_q;
      vld_d     = vld_q;
      flen_d    = flen_q;
      push      = 1'b0;
      push_word = shreg_q;
      case (state_q)
         ST_IDLE, ST_RECV: begin
            if (acc_byte) begin
               state_d = ST_RECV;
               len_d   = len_inc;
               if (len_inc > LEN_W'(MAX_FRAME)) bad_d = 1'b1;
               if (lane_q == 2'd3) begin
                  push      = 1'b1;
                  push_word = word_ins;
                  shreg_d   = '0;
                  lane_d    = 2'd0;
                  if (!push_ok) begin
                     bad_d   = 1'b1;
                     state_d = ST_DROP;
                  end
               end else begin
                  shreg_d = word_ins;
                  lane_d  = lane_q + 2'd1;
               end
            end
            // Abort takes priority over EOF and discards the partial word.
            if (in_frame && acc_abort) begin
               state_d = ST_FLUSH;
               bad_d   = 1'b1;
               pend_d  = 1'b0;
            end else if (in_frame && acc_eof) begin
               state_d = ST_FLUSH;
               pend_d  = !bad_d && (lane_d != 2'd0);
            end
         end
         ST_DROP: begin
            if (acc_byte) begin
               len_d = len_inc;
            end
            if (acc_eof || acc_abort) begin
               state_d = ST_FLUSH;
               pend_d  = 1'b0;
            end
         end
         ST_FLUSH: begin
            if (pend_q) begin
               push = 1'b1;
               if (push_ok) pend_d = 1'b0;
            end else if (f_empty) begin
               state_d = ST_REPORT;
               vld_d   = !bad_q;
               flen_d  = len_q;
            end
         end
         ST_REPORT: begin
            state_d = ST_IDLE;
            bad_d   = 1'b0;
            len_d   = '0;
            lane_d  = 2'd0;
            shreg_d = '0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         lane_q  <= 2'd0;
         len_q   <= '0;
         bad_q   <= 1'b0;
         pend_q  <= 1'b0;
         vld_q   <= 1'b0;
         flen_q  <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         lane_q  <= lane_d;
         len_q   <= len_d;
         bad_q   <= bad_d;
         pend_q  <= pend_d;
         vld_q   <= vld_d;
         flen_q  <= flen_d;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_q   <= 1'b0;
         data_q <= '0;
      end else begin
         wr_q <= pop;
         if (pop) data_q <= f_rdata;
      end
   end

   assign DATA_RECV       = data_q;
   assign WRITE_INTO_LSAB = wr_q;
   assign IRQ             = (state_q == ST_REPORT);
   assign IRQ_VLD         = vld_q;
   assign FRAME_LEN       = flen_q;

endmodule

// File: tb/tb_eth_recv_lsab_packer.sv
// Directed bench for the receive LSAB packer with hand-computed words.
module tb_eth_recv_lsab_packer;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [7:0]  IN_DATA = '0;
   logic        IN_STB = 1'b0;
   logic        IN_EOF = 1'b0;
   logic        IN_ABORT = 1'b0;
   logic        IN_READY;
   logic [1:0]  LSAB_RECV_TURN = 2'd0;
   logic        LSAB_FULL = 1'b0;
   logic [31:0] DATA_RECV;
   logic        WRITE_INTO_LSAB;
   logic        IRQ;
   logic        IRQ_VLD;
   logic [23:0] FRAME_LEN;

   eth_recv_lsab_packer dut (
      .CLK             (CLK),
      .RST             (RST),
      .IN_DATA         (IN_DATA),
      .IN_STB          (IN_STB),
      .IN_EOF          (IN_EOF),
      .IN_ABORT        (IN_ABORT),
      .IN_READY        (IN_READY),
      .LSAB_RECV_TURN  (LSAB_RECV_TURN),
      .LSAB_FULL       (LSAB_FULL),
      .DATA_RECV       (DATA_RECV),
      .WRITE_INTO_LSAB (WRITE_INTO_LSAB),
      .IRQ             (IRQ),
      .IRQ_VLD         (IRQ_VLD),
      .FRAME_LEN       (FRAME_LEN)
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_pass = 0;

   int          cyc = 0;
   logic [31:0] words[$];
   logic [31:0] exp_q[$];
   int          irq_cnt = 0;
   int          irq_cyc = 0;
   int          last_wr_cyc = 0;
   int          irq_with_wr = 0;
   logic        irq_vld_s = 1'b0;
   logic [23:0] irq_len_s = '0;
   logic        busy_rx = 1'b0;
   int          rdy_glitch = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (!RST) begin
         if (WRITE_INTO_LSAB) begin
            words.push_back(DATA_RECV);
            last_wr_cyc = cyc;
         end
         if (IRQ) begin
            irq_cnt++;
            irq_cyc   = cyc;
            irq_vld_s = IRQ_VLD;
            irq_len_s = FRAME_LEN;
            if (WRITE_INTO_LSAB) irq_with_wr++;
         end
         if (busy_rx && !IN_READY) rdy_glitch++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic send(input logic [7:0] b, input logic eof);
      int k = 0;
      while (!IN_READY && k < 50) begin
         @(posedge CLK); #1;
         k++;
      end
      IN_DATA = b;
      IN_STB  = 1'b1;
      IN_EOF  = eof;
      @(posedge CLK); #1;
      IN_STB  = 1'b0;
      IN_EOF  = 1'b0;
   endtask

   task automatic wait_irq(input int n0);
      int k = 0;
      while (irq_cnt == n0 && k < 200) begin
         @(posedge CLK); #1;
         k++;
      end
      repeat (4) @(posedge CLK);
      #1;
      check("irq_count", irq_cnt - n0, 1);
   endtask

   task automatic chk_words(input string tag);
      check({tag, "_nwords"}, words.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < words.size(); i++)
         check($sformatf("%s_w%0d", tag, i), words[i], exp_q[i]);
   endtask

   task automatic chk_reset(input string tag);
      check({tag, "_ready"}, IN_READY, 0);
      check({tag, "_wr"}, WRITE_INTO_LSAB, 0);
      check({tag, "_data"}, DATA_RECV, 0);
      check({tag, "_irq"}, IRQ, 0);
      check({tag, "_vld"}, IRQ_VLD, 0);
      check({tag, "_len"}, FRAME_LEN, 0);
   endtask

   initial begin
      int n0;
      #2;
      chk_reset("rst0");
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RST = 1'b0;
      @(posedge CLK); #1;

      // Case 1: two full words
      words.delete(); n0 = irq_cnt;
      for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
      wait_irq(n0);
      exp_q = '{32'h04030201, 32'h08070605};
      chk_words("t1");
      check("t1_vld", irq_vld_s, 1);
      check("t1_len", irq_len_s, 8);
      check("t1_order", irq_cyc > last_wr_cyc, 1);

      // Case 2: EOF on fifth byte, zero-padded tail
      words.delete(); n0 = irq_cnt;
      send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0);
      send(8'hDD, 0); send(8'hEE, 1);
      wait_irq(n0);
      exp_q = '{32'hDDCCBBAA, 32'h000000EE};
      chk_words("t2");
      check("t2_vld", irq_vld_s, 1);
      check("t2_len", irq_len_s, 5);
      check("t2_order", irq_cyc > last_wr_cyc, 1);

      // Case 3: LSAB full for 20 cycles overflows the FIFO
      words.delete(); n0 = irq_cnt;
      LSAB_FULL = 1'b1;
      busy_rx = 1'b1;
      rdy_glitch = 0;
      for (int i = 0; i < 40; i++) begin
         if (i == 20) LSAB_FULL = 1'b0;
         send(8'(i + 1), i == 39);
      end
      busy_rx = 1'b0;
      wait_irq(n0);
      exp_q = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
      chk_words("t3");
      check("t3_vld", irq_vld_s, 0);
      check("t3_len", irq_len_s, 40);
      check("t3_ready_glitch", rdy_glitch, 0);

      // Case 4: abort after six bytes, then a good 4-byte frame
      words.delete(); n0 = irq_cnt;
      for (int i = 0; i < 6; i++) send(8'h11 + 8'(i), 0);
      IN_ABORT = 1'b1;
      @(posedge CLK); #1;
      IN_ABORT = 1'b0;
      wait_irq(n0);
      exp_q = '{32'h14131211};
      chk_words("t4a");
      check("t4a_vld", irq_vld_s, 0);
      check("t4a_len", irq_len_s, 6);
      words.delete(); n0 = irq_cnt;
      for (int i = 0; i < 4; i++) send(8'h21 + 8'(i), i == 3);
      wait_irq(n0);
      exp_q = '{32'h24232221};
      chk_words("t4b");
      check("t4b_vld", irq_vld_s, 1);
      check("t4b_len", irq_len_s, 4);

      // Case 5: turn taken away, one word drained, turn taken again
      words.delete(); n0 = irq_cnt;
      LSAB_RECV_TURN = 2'd2;
      for (int i = 0; i < 12; i++) send(8'h31 + 8'(i), i == 11);
      repeat (10) @(posedge CLK);
      #1;
      check("t5_no_wr", words.size(), 0);
      LSAB_RECV_TURN = 2'd0;
      @(posedge CLK); #1;
      LSAB_RECV_TURN = 2'd2;
      repeat (10) @(posedge CLK);
      #1;
      check("t5_one_wr", words.size(), 1);
      check("t5_no_irq", irq_cnt - n0, 0);
      LSAB_RECV_TURN = 2'd0;
      wait_irq(n0);
      exp_q = '{32'h34333231, 32'h38373635, 32'h3C3B3A39};
      chk_words("t5");
      check("t5_vld", irq_vld_s, 1);
      check("t5_len", irq_len_s, 12);
      check("t5_order", irq_cyc > last_wr_cyc, 1);

      // Case 6: reset with two words buffered
      words.delete(); n0 = irq_cnt;
      LSAB_FULL = 1'b1;
      for (int i = 0; i < 9; i++) send(8'h41 + 8'(i), 0);
      RST = 1'b1;
      #1;
      chk_reset("t6");
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      LSAB_FULL = 1'b0;
      repeat (6) @(posedge CLK);
      #1;
      check("t6_no_wr", words.size(), 0);
      check("t6_no_irq", irq_cnt - n0, 0);
      for (int i = 0; i < 4; i++) send(8'h51 + 8'(i), i == 3);
      wait_irq(n0);
      exp_q = '{32'h54535251};
      chk_words("t6");
      check("t6_vld", irq_vld_s, 1);
      check("t6_len", irq_len_s, 4);

      check("irq_with_wr", irq_with_wr, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
